// File: rtl/alu_control_muldiv_if.sv
// Decode/issue bus between main control and the ALU control / mul-div block.
// The master drives the decoded instruction and operands; the slave returns select, stall and HI/LO state.
interface alu_control_muldiv_if #(
  parameter int WIDTH  = 32,
  parameter int AOP_W  = 3,
  parameter int ALUS_W = 4
);
  logic              Valid;
  logic [AOP_W-1:0]  Aop;
  logic [5:0]        Func;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic [ALUS_W-1:0] AluS;
  logic [WIDTH-1:0]  HiLoOut;
  logic              Stall;
  logic              Busy;
  logic              Done;
  logic              DivZero;
  logic              Illegal;
  logic [WIDTH-1:0]  Hi;
  logic [WIDTH-1:0]  Lo;

  modport master (
    output Valid, Aop, Func, A, B,
    input  AluS, HiLoOut, Stall, Busy, Done, DivZero, Illegal, Hi, Lo
  );

  modport slave (
    input  Valid, Aop, Func, A, B,
    output AluS, HiLoOut, Stall, Busy, Done, DivZero, Illegal, Hi, Lo
  );
endinterface

// File: rtl/alu_control_muldiv.sv
// ALU select decoder plus an iterative multiply/divide engine owning HI/LO.
// Magnitudes are processed unsigned over WIDTH steps; signs are applied in the FIX state.
module alu_control_muldiv #(
  parameter int WIDTH  = 32,
  parameter int AOP_W  = 3,
  parameter int ALUS_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  alu_control_muldiv_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              busy_q;
  logic [WIDTH-1:0]  wk_hi, wk_lo, mcand;
  logic              op_div, neg_q, neg_r, dz;
  logic [WIDTH-1:0]  hi_q, lo_q;

  // ---------------- decode ----------------
  logic              rtype, func_ok, is_mul, is_div, is_mf, sgn;
  logic [ALUS_W-1:0] alus_r, alus;

  always_comb begin
    rtype   = (bus.Aop == AOP_W'(3'b001));
    func_ok = 1'b1;
    alus_r  = ALUS_W'(4'b0000);
    case (bus.Func)
      F_ADD:  alus_r = ALUS_W'(4'b0010);
      F_SUB:  alus_r = ALUS_W'(4'b0110);
      F_AND:  alus_r = ALUS_W'(4'b0000);
      F_OR:   alus_r = ALUS_W'(4'b0001);
      F_SLT:  alus_r = ALUS_W'(4'b0111);
      F_SLL:  alus_r = ALUS_W'(4'b0000);
      F_MFHI: alus_r = ALUS_W'(4'b1000);
      F_MFLO: alus_r = ALUS_W'(4'b1001);
      F_MULT, F_MULTU, F_DIV, F_DIVU: alus_r = ALUS_W'(4'b0000);
      default: begin
        alus_r  = ALUS_W'(4'b1111);
        func_ok = 1'b0;
      end
    endcase

    alus = ALUS_W'(4'b0010);
    case (bus.Aop)
      AOP_W'(3'b000): alus = ALUS_W'(4'b0010);
      AOP_W'(3'b001): alus = alus_r;
      AOP_W'(3'b010): alus = ALUS_W'(4'b0110);
      AOP_W'(3'b011): alus = ALUS_W'(4'b0000);
      AOP_W'(3'b100): alus = ALUS_W'(4'b0001);
      AOP_W'(3'b101): alus = ALUS_W'(4'b0111);
      default:        alus = ALUS_W'(4'b0010);
    endcase
  end

  assign is_mul = rtype & (bus.Func == F_MULT || bus.Func == F_MULTU);
  assign is_div = rtype & (bus.Func == F_DIV  || bus.Func == F_DIVU);
  assign is_mf  = rtype & (bus.Func == F_MFHI || bus.Func == F_MFLO);
  assign sgn    = ~bus.Func[0];

  logic issue, dz_issue;
  assign issue    = bus.Valid & (is_mul | is_div) & (state == IDLE);
  assign dz_issue = issue & is_div & (bus.B == '0);

  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (sgn & bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign b_mag = (sgn & bus.B[WIDTH-1]) ? -bus.B : bus.B;

  // ---------------- one engine step ----------------
  logic [WIDTH:0]   sum, shifted, diff;
  assign sum     = {1'b0, wk_hi} + {1'b0, (wk_lo[0] ? mcand : '0)};
  assign shifted = {wk_hi, wk_lo[WIDTH-1]};
  // Remainder stays below the divisor, so bit WIDTH of diff is exactly the borrow.
  assign diff    = shifted - {1'b0, mcand};

  logic [2*WIDTH-1:0] prod, prod_res;
  logic [WIDTH-1:0]   hi_res, lo_res;
  assign prod     = {wk_hi, wk_lo};
  assign prod_res = neg_q ? -prod : prod;

  always_comb begin
    if (op_div) begin
      hi_res = neg_r ? -wk_hi : wk_hi;
      lo_res = neg_q ? -wk_lo : wk_lo;
    end else begin
      hi_res = prod_res[2*WIDTH-1:WIDTH];
      lo_res = prod_res[WIDTH-1:0];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (issue) state_nxt = dz_issue ? FIX : RUN;
      RUN:  if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      busy_q <= 1'b0;
      wk_hi  <= '0;
      wk_lo  <= '0;
      mcand  <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      case (state)
        IDLE: if (issue) begin
          op_div <= is_div;
          cnt    <= CW'(WIDTH-1);
          dz     <= dz_issue;
          if (dz_issue) begin
            // FIX writes wk_hi/wk_lo through unchanged: Hi = raw A, Lo = all ones.
            wk_hi <= bus.A;
            wk_lo <= '1;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
          end else if (is_div) begin
            wk_hi <= '0;
            wk_lo <= a_mag;
            mcand <= b_mag;
            neg_q <= sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_r <= sgn & bus.A[WIDTH-1];
          end else begin
            wk_hi <= '0;
            wk_lo <= b_mag;
            mcand <= a_mag;
            neg_q <= sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_r <= 1'b0;
          end
        end
        RUN: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          if (op_div) begin
            if (!diff[WIDTH]) wk_hi <= diff[WIDTH-1:0];
            else              wk_hi <= shifted[WIDTH-1:0];
            wk_lo <= {wk_lo[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            wk_hi <= sum[WIDTH:1];
            wk_lo <= {sum[0], wk_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi_q <= hi_res;
          lo_q <= lo_res;
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign bus.AluS    = alus;
  assign bus.Illegal = bus.Valid & rtype & ~func_ok;
  assign bus.Stall   = bus.Valid & (is_mul | is_div | is_mf) & busy_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = (state == FIX);
  assign bus.DivZero = (state == FIX) & dz;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;
  assign bus.HiLoOut = (rtype && bus.Func == F_MFHI) ? hi_q :
                       (rtype && bus.Func == F_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_alu_control_muldiv.sv
// Directed bench: decode table, mul/div results and timing, hazards and mid-run reset.
module tb_alu_control_muldiv;
  logic clk, rst;
  int checks, errors;

  alu_control_muldiv_if #(.WIDTH(32), .AOP_W(3), .ALUS_W(4)) bus ();

  alu_control_muldiv #(.WIDTH(32), .AOP_W(3), .ALUS_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [2:0] aop;
    logic [5:0] func;
    logic [3:0] alus;
    logic       ill;
  } dec_t;

  dec_t vecs[23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one mul/div and follow it until Busy drops; verify timing and result.
  task automatic run_op(input string name, input logic [5:0] func, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ebusy, input logic edz);
    int busy_n, done_at, done_n;
    logic dz_seen;
    busy_n = 0; done_at = -1; done_n = 0; dz_seen = 1'b0;
    @(negedge clk);
    bus.Valid = 1'b1; bus.Aop = 3'b001; bus.Func = func; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.Valid = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.Done) begin done_n++; done_at = k; dz_seen = bus.DivZero; end
      if (!bus.Busy) break;
      busy_n++;
    end
    chk({name, " busy cycles"}, 64'(busy_n), 64'(ebusy));
    chk({name, " done cycle"}, 64'(done_at), 64'(ebusy));
    chk({name, " done pulses"}, 64'(done_n), 64'd1);
    chk({name, " divzero"}, 64'(dz_seen), 64'(edz));
    chk({name, " hi"}, 64'(bus.Hi), 64'(ehi));
    chk({name, " lo"}, 64'(bus.Lo), 64'(elo));
  endtask

  initial begin
    int stall_miss, done_n, k_end;
    checks = 0; errors = 0;
    rst = 1'b1;
    bus.Valid = 1'b0; bus.Aop = 3'b000; bus.Func = 6'h00; bus.A = '0; bus.B = '0;

    vecs[0]  = '{1'b1, 3'b000, 6'h00, 4'h2, 1'b0};
    vecs[1]  = '{1'b1, 3'b010, 6'h00, 4'h6, 1'b0};
    vecs[2]  = '{1'b1, 3'b011, 6'h00, 4'h0, 1'b0};
    vecs[3]  = '{1'b1, 3'b100, 6'h00, 4'h1, 1'b0};
    vecs[4]  = '{1'b1, 3'b101, 6'h00, 4'h7, 1'b0};
    vecs[5]  = '{1'b1, 3'b110, 6'h00, 4'h2, 1'b0};
    vecs[6]  = '{1'b1, 3'b111, 6'h3f, 4'h2, 1'b0};
    vecs[7]  = '{1'b1, 3'b001, 6'h20, 4'h2, 1'b0};
    vecs[8]  = '{1'b1, 3'b001, 6'h22, 4'h6, 1'b0};
    vecs[9]  = '{1'b1, 3'b001, 6'h24, 4'h0, 1'b0};
    vecs[10] = '{1'b1, 3'b001, 6'h25, 4'h1, 1'b0};
    vecs[11] = '{1'b1, 3'b001, 6'h2a, 4'h7, 1'b0};
    vecs[12] = '{1'b1, 3'b001, 6'h00, 4'h0, 1'b0};
    vecs[13] = '{1'b1, 3'b001, 6'h10, 4'h8, 1'b0};
    vecs[14] = '{1'b1, 3'b001, 6'h12, 4'h9, 1'b0};
    vecs[15] = '{1'b1, 3'b001, 6'h18, 4'h0, 1'b0};
    vecs[16] = '{1'b1, 3'b001, 6'h19, 4'h0, 1'b0};
    vecs[17] = '{1'b1, 3'b001, 6'h1a, 4'h0, 1'b0};
    vecs[18] = '{1'b1, 3'b001, 6'h1b, 4'h0, 1'b0};
    vecs[19] = '{1'b1, 3'b001, 6'h3f, 4'hf, 1'b1};
    vecs[20] = '{1'b1, 3'b001, 6'h01, 4'hf, 1'b1};
    vecs[21] = '{1'b0, 3'b001, 6'h3f, 4'hf, 1'b0};
    vecs[22] = '{1'b0, 3'b010, 6'h20, 4'h6, 1'b0};

    // Decode is combinational; hold reset so mul/div funcs in the table cannot issue.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      bus.Valid = vecs[i].valid; bus.Aop = vecs[i].aop; bus.Func = vecs[i].func;
      #1;
      chk($sformatf("dec[%0d] alus", i), 64'(bus.AluS), 64'(vecs[i].alus));
      chk($sformatf("dec[%0d] illegal", i), 64'(bus.Illegal), 64'(vecs[i].ill));
    end

    @(negedge clk);
    bus.Valid = 1'b0; bus.Aop = 3'b000; bus.Func = 6'h00;
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy", 64'(bus.Busy), 64'd0);
    chk("rst done", 64'(bus.Done), 64'd0);
    chk("rst divzero", 64'(bus.DivZero), 64'd0);
    chk("rst hi", 64'(bus.Hi), 64'd0);
    chk("rst lo", 64'(bus.Lo), 64'd0);
    chk("rst stall", 64'(bus.Stall), 64'd0);
    bus.Aop = 3'b001; bus.Func = 6'h10; #1;
    chk("rst hilo", 64'(bus.HiLoOut), 64'd0);
    bus.Aop = 3'b000; bus.Func = 6'h00;

    run_op("mult",  6'h18, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0);
    run_op("multu", 6'h19, 32'd7, 32'hFFFFFFFD, 32'h00000006, 32'hFFFFFFEB, 33, 1'b0);
    run_op("div neg", 6'h1a, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
    run_op("div negb", 6'h1a, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b0);
    run_op("div min", 6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 1'b0);
    run_op("divu divz", 6'h1b, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, 1'b1);
    run_op("div divz", 6'h1a, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1, 1'b1);
    run_op("divu", 6'h1b, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);

    @(negedge clk);
    bus.Valid = 1'b1; bus.Aop = 3'b001; bus.Func = 6'h10; #1;
    chk("mfhi out", 64'(bus.HiLoOut), 64'd2);
    bus.Func = 6'h12; #1;
    chk("mflo out", 64'(bus.HiLoOut), 64'd14);
    chk("mflo idle stall", 64'(bus.Stall), 64'd0);
    bus.Valid = 1'b0;

    // Hazards: stalled mult, unstalled add, then mflo held until the result lands.
    @(negedge clk);
    bus.Valid = 1'b1; bus.Aop = 3'b001; bus.Func = 6'h18; bus.A = 32'd7; bus.B = 32'hFFFFFFFD;
    @(posedge clk); #1;
    bus.A = 32'd2; bus.B = 32'd2;
    @(negedge clk); #1;
    chk("haz mult stall", 64'(bus.Stall), 64'd1);
    @(negedge clk);
    bus.Aop = 3'b000; bus.Func = 6'h20; #1;
    chk("haz add stall", 64'(bus.Stall), 64'd0);
    chk("haz add alus", 64'(bus.AluS), 64'h2);
    bus.Aop = 3'b001; bus.Func = 6'h12;
    stall_miss = 0; done_n = 0; k_end = 0;
    for (int k = 3; k <= 60; k++) begin
      @(negedge clk); #1;
      if (!bus.Busy) begin k_end = k; break; end
      if (bus.Done) done_n++;
      if (bus.Stall !== 1'b1) stall_miss++;
    end
    chk("haz mflo stall misses", 64'(stall_miss), 64'd0);
    chk("haz release cycle", 64'(k_end), 64'd34);
    chk("haz done pulses", 64'(done_n), 64'd1);
    chk("haz release stall", 64'(bus.Stall), 64'd0);
    chk("haz mflo value", 64'(bus.HiLoOut), 64'hFFFFFFEB);
    @(posedge clk); #1;
    bus.Valid = 1'b0;
    @(negedge clk);
    chk("haz idle after mflo", 64'(bus.Busy), 64'd0);
    chk("haz hi", 64'(bus.Hi), 64'hFFFFFFFF);

    // Reset while the engine is mid-run.
    @(negedge clk);
    bus.Valid = 1'b1; bus.Aop = 3'b001; bus.Func = 6'h18; bus.A = 32'd3; bus.B = 32'd5;
    @(posedge clk); #1;
    bus.Valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst busy", 64'(bus.Busy), 64'd0);
    chk("midrst hi", 64'(bus.Hi), 64'd0);
    chk("midrst lo", 64'(bus.Lo), 64'd0);
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.Done || bus.Busy) done_n++;
    end
    chk("midrst no done", 64'(done_n), 64'd0);
    run_op("mult after rst", 6'h18, 32'd3, 32'd5, 32'd0, 32'd15, 33, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
